mcpu_param: RTL
===============

// Module: mcpu_param
// PURPOSE
//  Parametrised successor of the minimal accumulator CPU: same 4-instruction ISA (NOR, ADD, STA, JCC),
//  generalised to DW-bit data / (DW-2)-bit address, with separate registered address/data buses,
//  a memory ready handshake (wait states) and halt detection. Sits between the tile I/O mux and
//  external SRAM/ROM; one memory access per bus cycle.
// PARAMETERS
//  DW        8   data/accumulator width, >=4; address width AW = DW-2 (localparam), memory = 2^AW words
//  RESET_PC  0   address of first fetch after reset (AW bits)
// PORTS
//  clk       in   1    single clock, all state on rising edge
//  rst       in   1    synchronous reset, active-high
//  datain    in   DW   memory read data (instruction or operand), sampled when mem_req & ready
//  ready     in   1    memory access completes this cycle; ignored when mem_req=0
//  addr      out  AW   memory address (registered adreg)
//  dataout   out  DW   accumulator value (registered), write data for STA
//  mem_req   out  1    access in progress this cycle
//  mem_we    out  1    active-high write strobe, valid with mem_req in EXEC_STA
//  halted    out  1    CPU stopped in self-loop; sticky until rst
// BEHAVIOUR
//  - Instruction word: op = datain[DW-1:DW-2], operand = datain[AW-1:0].
//    op 00 NOR: acc <= ~(acc|mem[operand]); 01 ADD: {carry,acc} <= acc+mem[operand];
//    10 STA: mem[operand] <= acc; 11 JCC: jump to operand if carry=0, else clear carry, fall through.
//  - State regs: acc[DW-1:0], carry, pc[AW-1:0], adreg[AW-1:0], state (FETCH, EXEC_NOR, EXEC_ADD,
//    EXEC_STA, JCC_NT, HALT).
//  - Reset (rst=1 on edge): acc=0, carry=0, pc=RESET_PC, adreg=RESET_PC, state=FETCH, halted=0.
//    While rst=1: mem_req=0, mem_we=0. Reset overrides everything, incl. mid-wait-state or HALT.
//  - Stall rule: in FETCH/EXEC_* with ready=0, no register changes; addr, dataout, mem_we held stable.
//  - FETCH & ready: pc <= adreg+1 (mod 2^AW, wraps 2^AW-1 -> 0); adreg <= operand;
//    op 00/01/10 -> EXEC_NOR/EXEC_ADD/EXEC_STA; op 11 & carry=0 & operand==adreg -> HALT;
//    op 11 & carry=0 otherwise -> FETCH (taken, next fetch at operand); op 11 & carry=1 -> JCC_NT.
//  - EXEC_NOR/ADD & ready: update acc (ADD also carry = carry-out bit DW; NOR leaves carry),
//    adreg <= pc, -> FETCH.
//  - EXEC_STA: mem_we=1; on ready: adreg <= pc, -> FETCH; acc/carry unchanged.
//  - JCC_NT: mem_req=0, ready ignored; carry <= 0, adreg <= pc, -> FETCH (always 1 cycle).
//  - HALT: mem_req=0, mem_we=0, halted=1; all regs frozen until rst.
//  - mem_req = ~rst & state in {FETCH,EXEC_NOR,EXEC_ADD,EXEC_STA}; mem_we = ~rst & state==EXEC_STA.
//  - Latency with ready=1: NOR/ADD/STA 2 cycles, JCC taken 1, JCC not-taken 2; each ready=0 adds 1.
//  - Carry only changed by ADD (set/cleared) and JCC_NT (cleared); NOR/STA/taken JCC preserve it.
// TESTING (DW=8, AW=6 unless stated)
//  1 Reset: rst=1 for 2 cycles, ready=1 -> addr=0, dataout=0, mem_we=0, halted=0; first mem_req cycle addr=0.
//  2 ADD/carry: mem[0]=0x45, mem[5]=0xF0, mem[1]=0x46, mem[6]=0x20 -> acc=0xF0,c=0 after cycle 2; acc=0x10,c=1 after 4.
//  3 JCC not taken: mem[2]=0xCA with c=1 -> JCC_NT cycle has mem_req=0, c->0, next fetch addr=3 (not 10).
//  4 STA + stall: mem[3]=0x90, ready=0 for 3 cycles in EXEC_STA -> addr=16, mem_we=1, dataout=0x10 held 4 cycles, then fetch addr=4.
//  5 Halt / reset out: mem[4]=0xC4 with c=0 -> halted=1, mem_req=0 indefinitely; rst=1 one cycle -> halted=0, fetch addr=0.
//  6 Wrap + width: DW=6, NOR at addr 15 (mem[15]=0x00, operand 0) -> next fetch addr 0; repeat test 2 scaled to DW=12.

Source files
------------

// File: rtl/mcpu_param.sv
// Parametrised accumulator CPU: NOR/ADD/STA/JCC on DW-bit data with (DW-2)-bit address,
// registered address/data buses, ready-based wait states and self-loop halt detection.
module mcpu_param #(
   parameter int unsigned DW       = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   datain,
   input  logic            ready,
   output logic [DW-3:0]   addr,
   output logic [DW-1:0]   dataout,
   output logic            mem_req,
   output logic            mem_we,
   output logic            halted
);

   localparam int unsigned AW = DW - 2;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC_NOR,
      S_EXEC_ADD,
      S_EXEC_STA,
      S_JCC_NT,
      S_HALT
   } state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   acc_q, acc_d;
   logic            carry_q, carry_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [AW-1:0]   adreg_q, adreg_d;

   logic [1:0]      op_c;
   logic [AW-1:0]   operand_c;
   logic [DW:0]     sum_c;

   assign op_c      = datain[DW-1:DW-2];
   assign operand_c = datain[AW-1:0];
   assign sum_c     = {1'b0, acc_q} + {1'b0, datain};

   // Next-state: every register holds unless the current state completes its bus cycle
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      carry_d = carry_q;
      pc_d    = pc_q;
      adreg_d = adreg_q;
      case (state_q)
         S_FETCH: begin
            if (ready) begin
               pc_d    = adreg_q + AW'(1);
               adreg_d = operand_c;
               case (op_c)
                  2'b00:   state_d = S_EXEC_NOR;
                  2'b01:   state_d = S_EXEC_ADD;
                  2'b10:   state_d = S_EXEC_STA;
                  default: begin
                     // A taken jump onto itself can never leave: park the CPU
                     if (carry_q)                    state_d = S_JCC_NT;
                     else if (operand_c == adreg_q)  state_d = S_HALT;
                     else                            state_d = S_FETCH;
                  end
               endcase
            end
         end
         S_EXEC_NOR: begin
            if (ready) begin
               acc_d   = ~(acc_q | datain);
               adreg_d = pc_q;
               state_d = S_FETCH;
            end
         end
         S_EXEC_ADD: begin
            if (ready) begin
               acc_d   = sum_c[DW-1:0];
               carry_d = sum_c[DW];
               adreg_d = pc_q;
               state_d = S_FETCH;
            end
         end
         S_EXEC_STA: begin
            if (ready) begin
               adreg_d = pc_q;
               state_d = S_FETCH;
            end
         end
         S_JCC_NT: begin
            carry_d = 1'b0;
            adreg_d = pc_q;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         acc_q   <= '0;
         carry_q <= 1'b0;
         pc_q    <= AW'(RESET_PC);
         adreg_q <= AW'(RESET_PC);
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
         pc_q    <= pc_d;
         adreg_q <= adreg_d;
      end
   end

   assign addr    = adreg_q;
   assign dataout = acc_q;
   assign mem_req = ~rst & ((state_q == S_FETCH)    || (state_q == S_EXEC_NOR) ||
                            (state_q == S_EXEC_ADD) || (state_q == S_EXEC_STA));
   assign mem_we  = ~rst & (state_q == S_EXEC_STA);
   assign halted  = (state_q == S_HALT);

endmodule
